// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_pkg
// Shared definitions for the pipeline stage register and its skid entry.
//   PIPE_CNT_W_DEF : default width of the stall-cycle counter
//   main_op_e      : per-cycle update applied to the main entry
// Configuration macro: PIPE_SKID_EN (default off). When defined, the stage adds
// one skid entry so in_ready no longer depends on out_ready.
// -----------------------------------------------------------------------------
package pipe_stage_reg_pkg;

    localparam int PIPE_CNT_W_DEF = 16;

    // Update applied to the main entry at the next edge (reset/flush excluded).
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,  // keep valid and data
        MAIN_LOAD_IN   = 2'd1,  // take the upstream payload
        MAIN_LOAD_SKID = 2'd2,  // promote the skid entry into main
        MAIN_DRAIN     = 2'd3   // payload left downstream, nothing replaces it
    } main_op_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// One-entry skid store placed behind the main entry of pipe_stage_reg. It
// catches a payload accepted while main is occupied and stalled, which lets
// in_ready be a registered function of the skid state (plus suspend) only.
// Only instantiated when PIPE_SKID_EN is defined.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : drop the skid entry at the next edge
//   suspend_i         : freeze, no acceptance, state retained
//   main_v_i          : main entry currently valid
//   out_ready_i       : downstream ready
//   in_valid_i/in_data_i : upstream payload
//   in_ready_o        : stage can accept this cycle
//   skid_v_o/skid_d_o : skid entry state, read by the top to refill main
// -----------------------------------------------------------------------------
import pipe_stage_reg_pkg::*;

module pipe_skid_buf #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              suspend_i,
    input  logic              main_v_i,
    input  logic              out_ready_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              skid_v_o,
    output logic [DATA_W-1:0] skid_d_o
);

    logic              skid_v_q;
    logic              skid_v_d;
    logic [DATA_W-1:0] skid_d_q;
    logic [DATA_W-1:0] skid_d_d;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign in_ready_o = !suspend_i && !skid_v_q;
    assign in_xfer_s  = in_valid_i && in_ready_o;
    assign out_xfer_s = main_v_i && !suspend_i && out_ready_i;
    assign skid_v_o   = skid_v_q;
    assign skid_d_o   = skid_d_q;

    // Skid next state: empty when main drains it, fill when main is stalled.
    always_comb begin
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        if (out_xfer_s && skid_v_q) begin
            // Top moves skid into main this edge. in_ready was low, so no
            // new payload can arrive at the same time.
            skid_v_d = 1'b0;
        end else if (in_xfer_s && main_v_i && !out_xfer_s) begin
            skid_v_d = 1'b1;
            skid_d_d = in_data_i;
        end else begin
            skid_v_d = skid_v_q;
        end
    end

    // Skid state register with reset > flush > normal priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_v_q <= 1'b0;
            skid_d_q <= RESET_VAL;
        end else if (flush_i) begin
            skid_v_q <= 1'b0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised inter-stage register with valid/ready handshake, synchronous
// flush, suspend (freeze) and a saturating count of back-pressured cycles.
// Configuration macro: PIPE_SKID_EN (default off) adds one skid entry through
// pipe_skid_buf, removing the out_ready -> in_ready combinational path.
// Ports:
//   cpu_clk, cpu_rst     : clock, synchronous active-high reset
//   flush                : discard held entries at the next edge
//   suspend              : freeze stage, outputs masked, state retained
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   stall_cnt            : saturating count of cycles main was held back
// -----------------------------------------------------------------------------
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = PIPE_CNT_W_DEF
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              suspend,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Saturating increment: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic              main_v_q;
    logic              main_v_d;
    logic [DATA_W-1:0] main_d_q;
    logic [DATA_W-1:0] main_d_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              stall_s;
    main_op_e          main_op_s;

    assign out_valid  = main_v_q && !suspend;
    assign out_data   = main_d_q;
    assign stall_cnt  = stall_cnt_q;
    assign out_xfer_s = out_valid && out_ready;
    assign in_xfer_s  = in_valid && in_ready;

`ifdef PIPE_SKID_EN
    logic              skid_v_s;
    logic [DATA_W-1:0] skid_d_s;

    pipe_skid_buf #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk_i       (cpu_clk),
        .rst_i       (cpu_rst),
        .flush_i     (flush),
        .suspend_i   (suspend),
        .main_v_i    (main_v_q),
        .out_ready_i (out_ready),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .skid_v_o    (skid_v_s),
        .skid_d_o    (skid_d_s)
    );
`else
    // Single entry: room exists if main is empty or leaving this cycle.
    assign in_ready = !suspend && (!main_v_q || out_ready);
`endif

    // Select what happens to the main entry; order is main, skid, new input.
    always_comb begin
        main_op_s = MAIN_HOLD;
`ifdef PIPE_SKID_EN
        if (out_xfer_s && skid_v_s) begin
            main_op_s = MAIN_LOAD_SKID;
        end else if (in_xfer_s && (!main_v_q || out_xfer_s)) begin
            main_op_s = MAIN_LOAD_IN;
        end else if (out_xfer_s) begin
            main_op_s = MAIN_DRAIN;
        end else begin
            main_op_s = MAIN_HOLD;
        end
`else
        if (in_xfer_s && (!main_v_q || out_xfer_s)) begin
            main_op_s = MAIN_LOAD_IN;
        end else if (out_xfer_s) begin
            main_op_s = MAIN_DRAIN;
        end else begin
            main_op_s = MAIN_HOLD;
        end
`endif
    end

    // Main entry next state; data only changes on a load, bubbles keep stale data.
    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        case (main_op_s)
            MAIN_LOAD_IN: begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end
`ifdef PIPE_SKID_EN
            MAIN_LOAD_SKID: begin
                main_v_d = 1'b1;
                main_d_d = skid_d_s;
            end
`endif
            MAIN_DRAIN: begin
                main_v_d = 1'b0;
            end
            MAIN_HOLD: begin
                main_v_d = main_v_q;
            end
            default: begin
                main_v_d = main_v_q;
                main_d_d = main_d_q;
            end
        endcase
    end

    // Stall counter next state: main held by back-pressure or suspend.
    always_comb begin
        stall_s = main_v_q && (!out_ready || suspend);
        if (stall_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Main entry register with reset > flush > normal; flush keeps stale data.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            main_v_q <= 1'b0;
            main_d_q <= RESET_VAL;
        end else if (flush) begin
            main_v_q <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it counting.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg. A second instance with CNT_W = 2
// shares all inputs to exercise counter saturation. The reference model treats
// the stage as a FIFO queue of capacity 1 (or 2 with PIPE_SKID_EN).
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DW  = 32;
    localparam logic [31:0] RV  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        suspend;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] stall_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  stall_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] mq[$];
    logic [31:0] m_head;
    int          m_cnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(16)) dut (
        .cpu_clk(clk), .cpu_rst(rst), .flush(flush), .suspend(suspend),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV), .CNT_W(2)) dut2 (
        .cpu_clk(clk), .cpu_rst(rst), .flush(flush), .suspend(suspend),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .stall_cnt(stall_cnt2)
    );

    function automatic logic m_in_ready();
`ifdef PIPE_SKID_EN
        return !suspend && (mq.size() < 2);
`else
        return !suspend && (mq.size() == 0 || out_ready);
`endif
    endfunction

    function automatic logic m_out_valid();
        return (mq.size() > 0) && !suspend;
    endfunction

    function automatic logic [15:0] m_cnt16();
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endfunction

    function automatic logic [1:0] m_cnt2();
        return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
    endfunction

    // Apply one clock edge to the model using the current inputs.
    task automatic model_edge();
        logic ix;
        logic ox;
        if (rst) begin
            mq.delete();
            m_head = RV;
            m_cnt  = 0;
        end else begin
            if (mq.size() > 0 && (!out_ready || suspend)) m_cnt++;
            if (flush) begin
                mq.delete();
            end else if (!suspend) begin
                ix = in_valid && m_in_ready();
                ox = (mq.size() > 0) && out_ready;
                if (ox) void'(mq.pop_front());
                if (ix) mq.push_back(in_data);
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== RV) begin n_fail++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); end
        n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        n_checks++; if (stall_cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_stall_cnt2 got=%0d exp=0", stall_cnt2); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            in_valid = (i <= 8);
            in_data  = 32'(i);
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
            if (i > 1) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== 32'(i - 1)) begin
                    n_fail++; $display("FAIL stream_out i=%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 32'(i - 1));
                end
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int          c0;
        logic        sent6;
        logic [31:0] got[$];
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5;
        tick();
        c0 = m_cnt;
        out_ready = 1'b0; in_data = 32'h6; sent6 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin
                n_fail++; $display("FAIL bp_hold k=%0d got v=%b d=%h exp v=1 d=5", k, out_valid, out_data);
            end
`ifdef PIPE_SKID_EN
            n_checks++; if (in_ready !== (k == 0)) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, in_ready, (k == 0)); end
`else
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
`endif
            if (in_valid && m_in_ready()) sent6 = 1'b1;
            tick();
            in_valid = !sent6;
        end
        n_checks++; if (stall_cnt !== 16'(c0 + 3)) begin n_fail++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, c0 + 3); end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got.push_back(out_data);
            if (in_valid && m_in_ready()) sent6 = 1'b1;
            tick();
            in_valid = !sent6;
        end
        in_valid = 1'b0;
        n_checks++; if (got.size() != 2) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=2", got.size()); end
        else begin
            n_checks++; if (got[0] !== 32'h5 || got[1] !== 32'h6) begin
                n_fail++; $display("FAIL bp_drain_order got=%h,%h exp=5,6", got[0], got[1]);
            end
        end
    endtask

    task automatic test_flush();
        logic [15:0] c0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h9;
        tick();
        flush = 1'b1; in_data = 32'hA;
        @(negedge clk);
        c0 = stall_cnt;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid k=%0d got=%b exp=0", k, out_valid); end
            n_checks++; if (out_data === 32'hA) begin n_fail++; $display("FAIL flush_leak k=%0d got=%h exp=not A", k, out_data); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready k=%0d got=%b exp=1", k, in_ready); end
            n_checks++; if (stall_cnt !== c0) begin n_fail++; $display("FAIL flush_stall k=%0d got=%0d exp=%0d", k, stall_cnt, c0); end
            tick();
        end
    endtask

    task automatic test_suspend();
        int c0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h7;
        tick();
        in_valid = 1'b0; suspend = 1'b1;
        c0 = m_cnt;
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL susp_mask k=%0d got ov=%b ir=%b exp 0,0", k, out_valid, in_ready);
            end
            n_checks++; if (out_data !== 32'h7) begin n_fail++; $display("FAIL susp_data k=%0d got=%h exp=7", k, out_data); end
            tick();
        end
        n_checks++; if (stall_cnt !== 16'(c0 + 4)) begin n_fail++; $display("FAIL susp_stall got=%0d exp=%0d", stall_cnt, c0 + 4); end
        suspend = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h7) begin
            n_fail++; $display("FAIL susp_release got v=%b d=%h exp v=1 d=7", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h33;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (stall_cnt2 !== ((k > 3) ? 2'd3 : 2'(k))) begin
                n_fail++; $display("FAIL sat_cnt2 k=%0d got=%0d exp=%0d", k, stall_cnt2, (k > 3) ? 3 : k);
            end
            n_checks++; if (stall_cnt !== 16'(k)) begin n_fail++; $display("FAIL sat_cnt16 k=%0d got=%0d exp=%0d", k, stall_cnt, k); end
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            suspend   = ($urandom_range(0, 7) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            @(negedge clk);
            n_checks++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, m_in_ready()); end
            n_checks++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, m_out_valid()); end
            n_checks++; if (out_data !== m_head) begin n_fail++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, out_data, m_head); end
            n_checks++; if (stall_cnt !== m_cnt16()) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt16()); end
            n_checks++; if (stall_cnt2 !== m_cnt2()) begin n_fail++; $display("FAIL rnd_stall2 c=%0d got=%0d exp=%0d", c, stall_cnt2, m_cnt2()); end
            tick();
        end
        rst = 1'b0; flush = 1'b0; suspend = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; suspend = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        m_head = RV; m_cnt = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_suspend();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the next generation of the fixed-field inter-stage latches between the IF/ID/EX/MEM/WB stages. It carries one DATA_W-bit payload plus a valid bit across one clock. It adds a valid/ready handshake, a synchronous flush, a freeze input compatible with the existing `suspend` semantics, and a saturating stall-cycle counter. Stage payloads such as pc4, alu_C, wR and the control bits are concatenated by the instantiating stage into `in_data`.

## Interface
- DATA_W, 32: payload width in bits, minimum 1
- RESET_VAL, {DATA_W{1'b0}}: value loaded into `out_data`, and into the skid entry when present, on reset
- CNT_W, 16: width of `stall_cnt`, minimum 1
- cpu_clk  in  1  clock, rising edge
- cpu_rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries at the next edge
- suspend  in  1  freeze stage: no accept, no drain, state retained
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload valid toward downstream
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  registered payload
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- Internal main entry: `main_v` and `main_d`. `out_data = main_d`.
- `out_valid = main_v && !suspend`. Suspend therefore masks the output, so no transfer occurs in either direction.
- Edge priority: cpu_rst > flush > suspend > normal.
- cpu_rst: `main_v` = 0, `main_d` = RESET_VAL, skid cleared, `stall_cnt` = 0.
- flush (not in reset): `main_v` = 0 and skid valid = 0. A same-cycle input transfer is discarded. `main_d` keeps its value. `stall_cnt` is unaffected.
- suspend (no reset, no flush): all state holds. `in_ready` = 0.
- Normal, no skid:
  - `in_ready = !suspend && (!main_v || out_ready)`.
  - On an input transfer, `main_d <= in_data` and `main_v <= 1`.
  - Otherwise, if there is an output transfer, `main_v <= 0`.
  - `main_d` is never updated without an input transfer; a bubble holds the stale data.
- `stall_cnt` increments when `main_v && (!out_ready || suspend)` and not in reset. It saturates at all-ones and is cleared only by cpu_rst.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: one transfer per cycle with `out_ready` held at 1, in both modes.
- Without skid: `in_ready` depends combinationally on `out_ready` and `suspend`.
- With skid: `in_ready` depends combinationally only on `suspend`; there is no `out_ready` to `in_ready` path.
- Reset values: `out_valid` = 0, `out_data` = RESET_VAL, `stall_cnt` = 0. `in_ready` = 1 in the cycle after reset if `suspend` = 0.
- Reset asserted mid-transfer: the payload is dropped and there is no output transfer in that cycle's successor.

## Configuration
- PIPE_SKID_EN defined:
  - Adds one skid entry (`skid_v`, `skid_d`). `in_ready = !suspend && !skid_v`, with `skid_v` registered.
  - If an input transfer occurs while `main_v && !out_ready`, the payload goes to skid.
  - On an output transfer with `skid_v`, `main_d <= skid_d` and `skid_v <= 0`. A simultaneous input transfer then refills main directly only if skid was empty.
  - Order is always preserved: main, then skid, then new input.
- PIPE_SKID_EN undefined: single entry, behaviour as in Operation, no skid storage synthesised.

## Structure
- `defines.vh` gains `PIPE_SKID_EN` (commented default: off) and a `PIPE_CNT_W_DEF` constant of 16.
- One sub-module, `pipe_skid_buf`, holds the skid entry and its control. It is instantiated only under PIPE_SKID_EN.
- `stall_cnt` logic stays in the top module.

## Test plan
- Reset with cpu_rst = 1 for 2 cycles, DATA_W = 32, RESET_VAL = 32'hDEAD_BEEF -> `out_valid` = 0, `out_data` = 32'hDEAD_BEEF, `stall_cnt` = 0, `in_ready` = 1 after release.
- Stream 0x1..0x8 with `out_ready` = 1 -> `out_data` shows 0x1..0x8 on consecutive cycles, each 1 cycle after its input, with no gaps.
- Hold `out_ready` = 0 for 3 cycles with 0x5 held -> `out_data` stays 0x5 and `stall_cnt` = 3. No skid: `in_ready` = 0. Skid: 0x6 is accepted once, then `in_ready` = 0, and 0x5 then 0x6 drain in order.
- Assert `flush` together with `in_valid` and data 0xA -> next cycle `out_valid` = 0, 0xA never appears, skid empty, `stall_cnt` unchanged.
- `suspend` = 1 for 4 cycles with a valid 0x7 held -> `out_valid` = 0 and `in_ready` = 0 throughout, `stall_cnt` += 4, 0x7 presented after release.
- CNT_W = 2 with 5 back-pressured cycles -> `stall_cnt` saturates at 3.
